// File: rtl/cmp_digit_serial.sv
// Digit-serial resolver for the 2-bit magnitude comparator: MSB digit first, first unequal digit decides.
// Optional sticky one-hot beat check (err port) is enabled by defining CMPSER_ONEHOT_CHK_EN.
module cmp_digit_serial #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             e_in,
  input  logic             l_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [CNT_W-1:0] digit_cnt
`ifdef CMPSER_ONEHOT_CHK_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {R_EQ, R_LT, R_GT} res_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DIGITS);

  // Priority l > g > e; a beat with no flag set reads as equal.
  function automatic res_e decode_beat(input logic [2:0] elg);
    res_e r;
    priority casez (elg)
      3'b?1?:  r = R_LT;
      3'b??1:  r = R_GT;
      default: r = R_EQ;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == MAX_CNT) ? c : c + 1'b1;
  endfunction

  function automatic logic [2:0] res_flags(input res_e r);
    logic [2:0] f;
    case (r)
      R_LT:    f = 3'b010;
      R_GT:    f = 3'b001;
      default: f = 3'b100;
    endcase
    return f;
  endfunction

  state_e           state_q, state_d;
  res_e             res_q;
  res_e             beat_res;
  res_e             res_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             eq_q, lt_q, gt_q;
  logic             accept;
  logic             last_beat;

  always_comb begin
    accept    = (state_q == S_RUN) && in_valid && !start;
    beat_res  = decode_beat({e_in, l_in, g_in});
    // Once a digit differs the verdict is frozen for the rest of the compare.
    res_nxt   = (res_q == R_EQ) ? beat_res : res_q;
    last_beat = accept && (cnt_q == LAST_CNT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)          state_d = S_RUN;
        else if (last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= R_EQ;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        res_q <= R_EQ;
        cnt_q <= '0;
      end else if (accept) begin
        res_q <= res_nxt;
        cnt_q <= cnt_inc(cnt_q);
      end
      // Final flags are captured on the closing beat so they are valid in the DONE cycle.
      if (last_beat) {eq_q, lt_q, gt_q} <= res_flags(res_nxt);
    end
  end

`ifdef CMPSER_ONEHOT_CHK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (start)
      err_q <= 1'b0;
    else if (accept && !$onehot({e_in, l_in, g_in}))
      err_q <= 1'b1;
  end

  assign err = err_q;
`endif

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign gt        = gt_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_digit_serial.sv
// Directed bench for cmp_digit_serial (DIGITS=4); err checks compile in with CMPSER_ONEHOT_CHK_EN.
module tb_cmp_digit_serial;
  localparam int DIGITS = 4;
  localparam int CNT_W  = 3;

  localparam logic [2:0] BE = 3'b100;
  localparam logic [2:0] BL = 3'b010;
  localparam logic [2:0] BG = 3'b001;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, e_in, l_in, g_in;
  logic             busy, done, eq, lt, gt;
  logic [CNT_W-1:0] digit_cnt;
`ifdef CMPSER_ONEHOT_CHK_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cmp_digit_serial #(.DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .e_in      (e_in),
    .l_in      (l_in),
    .g_in      (g_in),
    .busy      (busy),
    .done      (done),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt),
    .digit_cnt (digit_cnt)
`ifdef CMPSER_ONEHOT_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are observed at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] elg);
    start    = s;
    in_valid = v;
    {e_in, l_in, g_in} = elg;
    tick();
  endtask

  task automatic check_flags(input string tag, input logic [2:0] exp_elg);
    check({tag, "_eq"}, 32'(eq), 32'(exp_elg[2]));
    check({tag, "_lt"}, 32'(lt), 32'(exp_elg[1]));
    check({tag, "_gt"}, 32'(gt), 32'(exp_elg[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b0, 3'b000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; e_in = 1'b0; l_in = 1'b0; g_in = 1'b0;
    #1;
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_flags("rst", 3'b000);
    check("rst_cnt", 32'(digit_cnt), 0);
`ifdef CMPSER_ONEHOT_CHK_EN
    check("rst_err", 32'(err), 0);
`endif

    // 1: E,E,G,L -> GT, done at cycle 5
    drive(1'b1, 1'b0, 3'b000);
    check("t1_busy", 32'(busy), 1);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BG);
    check("t1_nodone", 32'(done), 0);
    drive(1'b0, 1'b1, BL);
    check("t1_done", 32'(done), 1);
    check_flags("t1", 3'b001);
    check("t1_cnt", 32'(digit_cnt), 4);
    drive(1'b0, 1'b0, 3'b000);
    check("t1_pulse", 32'(done), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // 2: E,E,E,E -> EQ, then L,G,G,G -> LT with flags held between
    drive(1'b1, 1'b0, 3'b000);
    check_flags("t2_hold_gt", 3'b001);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, BE);
    check("t2a_done", 32'(done), 1);
    check_flags("t2a", 3'b100);
    drive(1'b0, 1'b0, 3'b000);
    check_flags("t2_idle_hold", 3'b100);
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, BL);
    check_flags("t2_run_hold", 3'b100);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BG);
    check("t2b_done", 32'(done), 1);
    check_flags("t2b", 3'b010);

    // 3: in_valid in IDLE ignored; gapped beats 1,0,1,0,0,1,1
    do_reset();
    drive(1'b0, 1'b1, BL);
    check("t3_idle_cnt", 32'(digit_cnt), 0);
    check("t3_idle_busy", 32'(busy), 0);
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b0, BL);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b0, BL);
    drive(1'b0, 1'b0, BL);
    check("t3_cnt_gap", 32'(digit_cnt), 2);
    drive(1'b0, 1'b1, BG);
    check("t3_nodone", 32'(done), 0);
    drive(1'b0, 1'b1, BL);
    check("t3_done", 32'(done), 1);
    check_flags("t3", 3'b001);

    // 4: restart with 3rd beat, then E,L,E,E; restart in DONE; restart on last beat
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BG);
    drive(1'b1, 1'b1, BG);
    check("t4_abort_done", 32'(done), 0);
    check("t4_abort_cnt", 32'(digit_cnt), 0);
    check("t4_abort_busy", 32'(busy), 1);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BL);
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BE);
    check("t4_done", 32'(done), 1);
    check_flags("t4", 3'b010);
    drive(1'b1, 1'b0, 3'b000);
    check("t4_restart_busy", 32'(busy), 1);
    check("t4_restart_cnt", 32'(digit_cnt), 0);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BG);
    drive(1'b1, 1'b1, BG);
    check("t4_lastabort_done", 32'(done), 0);
    check("t4_lastabort_cnt", 32'(digit_cnt), 0);
    check_flags("t4_lastabort_hold", 3'b010);

    // 5: rst after two beats of a running compare
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BE);
    rst = 1'b1;
    drive(1'b0, 1'b1, BE);
    rst = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check_flags("t5", 3'b000);
    check("t5_cnt", 32'(digit_cnt), 0);

    // 6: non-one-hot beat {e,l,g}=011 decodes as LT
    drive(1'b1, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 3'b011);
`ifdef CMPSER_ONEHOT_CHK_EN
    check("t6_err_set", 32'(err), 1);
`endif
    drive(1'b0, 1'b1, BE);
    drive(1'b0, 1'b1, BG);
    drive(1'b0, 1'b1, BE);
    check("t6_done", 32'(done), 1);
    check_flags("t6", 3'b010);
    drive(1'b0, 1'b0, 3'b000);
`ifdef CMPSER_ONEHOT_CHK_EN
    check("t6_err_sticky", 32'(err), 1);
    drive(1'b1, 1'b0, 3'b000);
    check("t6_err_clr", 32'(err), 0);
    drive(1'b0, 1'b1, BE);
    check("t6_err_onehot", 32'(err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
